// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and width default for the counter slice.
package gray_pkg;

  localparam int unsigned GRAY_W_DEFAULT = 4;

  // Binary to Gray for a value of width w (w <= 32); bits above w are ignored.
  function automatic logic [31:0] bin2gray(input logic [31:0] b, input int unsigned w);
    logic [31:0] mask;
    logic [31:0] bm;
    mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    bm   = b & mask;
    return bm ^ (bm >> 1);
  endfunction

  // Gray to binary for a value of width w (w <= 32); prefix XOR from the MSB down.
  function automatic logic [31:0] gray2bin(input logic [31:0] g, input int unsigned w);
    logic [31:0] mask;
    logic [31:0] gm;
    logic [31:0] r;
    mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    gm   = g & mask;
    r    = gm;
    for (int unsigned i = 1; i < 32; i++) begin
      r = r ^ (gm >> i);
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2gray_enc.sv
// Combinational W-bit binary-to-Gray encoder.
module bin2gray_enc #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] b,
  output logic [W-1:0] g
);

  // Each Gray bit is the XOR of adjacent binary bits; the MSB passes through.
  always_comb begin
    g        = '0;
    g[W-1]   = b[W-1];
    for (int unsigned i = 0; i < W - 1; i++) begin
      g[i] = b[i+1] ^ b[i];
    end
  end

endmodule

// File: rtl/bintogray_cnt_s.sv
// Up/down binary counter with registered Gray output and wrap pulse.
// Optional Gray single-step checker enabled by defining GRAY_CHECK_EN;
// without it gray_err is tied low and the port list is unchanged.
module bintogray_cnt_s
  import gray_pkg::*;
#(
  parameter int unsigned W = GRAY_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         up,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] bin,
  output logic [W-1:0] gray,
  output logic         wrap,
  output logic         gray_err
);

  logic [W-1:0] bin_q;
  logic [W-1:0] bin_d;
  logic [W-1:0] gray_q;
  logic [W-1:0] gray_d;
  logic         wrap_q;
  logic         wrap_d;

  // Next count: load beats step beats hold; wrap judged on the pre-step value.
  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    if (load) begin
      bin_d = load_val;
    end else if (en) begin
      if (up) begin
        bin_d  = bin_q + W'(1);
        wrap_d = (bin_q == '1);
      end else begin
        bin_d  = bin_q - W'(1);
        wrap_d = (bin_q == '0);
      end
    end
  end

  // Gray is encoded from the next count so it lands in the same edge as bin.
  bin2gray_enc #(.W(W)) u_enc (
    .b (bin_d),
    .g (gray_d)
  );

  // Counter, Gray and wrap registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign bin  = bin_q;
  assign gray = gray_q;
  assign wrap = wrap_q;

`ifdef GRAY_CHECK_EN
  logic [W-1:0] gray_prev_q;
  logic         chk_vld_q;
  logic         err_q;

  // chk_vld_q marks that the gray_prev->gray transition came from a non-load
  // edge other than the first after reset, so it must be a single-bit step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gray_prev_q <= '0;
      chk_vld_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      gray_prev_q <= gray_q;
      chk_vld_q   <= !load;
      if (chk_vld_q && ($countones(gray_q ^ gray_prev_q) > 1)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign gray_err = err_q;
`else
  assign gray_err = 1'b0;
`endif

endmodule

// File: tb/tb_bintogray_cnt_s.sv
// Directed vector bench for bintogray_cnt_s at W=4.
module tb_bintogray_cnt_s;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] bin;
  logic [3:0] gray;
  logic       wrap;
  logic       gray_err;

  int checks;
  int errors;

  typedef struct {
    string      name;
    logic       load;
    logic       en;
    logic       up;
    logic [3:0] lv;
    logic [3:0] eb;
    logic [3:0] eg;
    logic       ew;
  } vec_t;

  vec_t vq[$];

  bintogray_cnt_s #(.W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .bin      (bin),
    .gray     (gray),
    .wrap     (wrap),
    .gray_err (gray_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input string nm, input logic ld, input logic e, input logic u,
                     input logic [3:0] lv, input logic [3:0] eb, input logic [3:0] eg,
                     input logic ew);
    vec_t v;
    v.name = nm; v.load = ld; v.en = e; v.up = u; v.lv = lv;
    v.eb = eb; v.eg = eg; v.ew = ew;
    vq.push_back(v);
  endtask

  initial begin
    logic [3:0] gseq [16];
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    en       = 1'b0;
    up       = 1'b0;
    load     = 1'b0;
    load_val = '0;

    // Hand-computed Gray walk for bin = 1..15, 0
    gseq = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
             4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

    // count-up walk from reset
    for (int i = 0; i < 16; i++) begin
      add("up_walk", 1'b0, 1'b1, 1'b1, 4'h0, 4'((i + 1) % 16), gseq[i], (i == 15));
    end
    add("hold_after_wrap", 1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0);
    add("down_from_0",     1'b0, 1'b1, 1'b0, 4'h0, 4'hF, 4'h8, 1'b1);
    add("hold_wrap_drop",  1'b0, 1'b0, 1'b0, 4'h0, 4'hF, 4'h8, 1'b0);
    add("load_over_en",    1'b1, 1'b1, 1'b1, 4'hA, 4'hA, 4'hF, 1'b0);
    add("up_after_load",   1'b0, 1'b1, 1'b1, 4'h0, 4'hB, 4'hE, 1'b0);
    add("load_F",          1'b1, 1'b0, 1'b0, 4'hF, 4'hF, 4'h8, 1'b0);
    add("up_from_F",       1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 1'b1);
    add("load_5",          1'b1, 1'b0, 1'b1, 4'h5, 4'h5, 4'h7, 1'b0);
    for (int i = 0; i < 4; i++) begin
      add("alt_up",   1'b0, 1'b1, 1'b1, 4'h0, 4'h6, 4'h5, 1'b0);
      add("alt_down", 1'b0, 1'b1, 1'b0, 4'h0, 4'h5, 4'h7, 1'b0);
    end

    // Reset state
    #12;
    chk("rst_bin", 32'(bin), 32'h0);
    chk("rst_gray", 32'(gray), 32'h0);
    chk("rst_wrap", 32'(wrap), 32'h0);
    chk("rst_gray_err", 32'(gray_err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      load     = vq[i].load;
      en       = vq[i].en;
      up       = vq[i].up;
      load_val = vq[i].lv;
      @(posedge clk);
      #1;
      chk({vq[i].name, "_bin"},  32'(bin),  32'(vq[i].eb));
      chk({vq[i].name, "_gray"}, 32'(gray), 32'(vq[i].eg));
      chk({vq[i].name, "_wrap"}, 32'(wrap), 32'(vq[i].ew));
    end
    @(negedge clk);
    load = 1'b0; en = 1'b0;
    chk("table_gray_err", 32'(gray_err), 32'h0);

    // Mid-count async reset: load 0, count to 6, reset between edges
    load = 1'b1; load_val = 4'h0;
    @(negedge clk);
    load = 1'b0; en = 1'b1; up = 1'b1;
    repeat (6) @(negedge clk);
    en = 1'b0;
    chk("pre_rst_bin", 32'(bin), 32'h6);
    chk("pre_rst_gray", 32'(gray), 32'h5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_bin", 32'(bin), 32'h0);
    chk("async_rst_gray", 32'(gray), 32'h0);
    chk("async_rst_wrap", 32'(wrap), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1; up = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_bin", 32'(bin), 32'h1);
    chk("post_rst_gray", 32'(gray), 32'h1);
    @(negedge clk);
    en = 1'b0;

`ifdef GRAY_CHECK_EN
    // Legal random traffic must never raise the checker
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      load     = ($urandom_range(0, 15) == 0);
      en       = $urandom_range(0, 1) == 1;
      up       = $urandom_range(0, 1) == 1;
      load_val = 4'($urandom_range(0, 15));
    end
    @(negedge clk);
    load = 1'b0; en = 1'b0;
    @(negedge clk);
    chk("random_gray_err", 32'(gray_err), 32'h0);

    // Illegal 3 -> C jump on a non-load edge
    load = 1'b1; load_val = 4'h2;
    @(negedge clk);
    load = 1'b0;
    chk("load2_gray", 32'(gray), 32'h3);
    @(negedge clk);
    force dut.gray_q = 4'hC;
    @(negedge clk);
    release dut.gray_q;
    @(negedge clk);
    chk("bad_step_gray_err", 32'(gray_err), 32'h1);
    repeat (3) @(negedge clk);
    chk("sticky_gray_err", 32'(gray_err), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_clears_gray_err", 32'(gray_err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
